// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux select scanner: state encoding, defaults and
// the dwell counter width.
package mux_scan_pkg;

    localparam int DEF_SEL_W = 2;
    localparam int DEF_DWELL = 1;
    localparam int DWELL_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Reload value for the settle counter: SETTLE lasts exactly dwell cycles.
    function automatic logic [DWELL_W-1:0] dwell_load(input int dwell);
        return DWELL_W'(dwell - 1);
    endfunction

endpackage

// File: rtl/mux_select_scanner_dwell_timer.sv
// Loadable down-counter that times the SETTLE phase of each channel.
module dwell_timer
    import mux_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_value,
    output logic [DWELL_W-1:0] value,
    output logic               zero
);

    assign zero = (value == '0);

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !zero) begin
            value <= value - DWELL_W'(1);
        end
    end

endmodule

// File: rtl/mux_select_scanner.sv
// Steps the 4x1 mux select through every channel, dwells, samples y once per
// channel and publishes the assembled word with a one-cycle strobe.
module mux_select_scanner
    import mux_scan_pkg::*;
#(
    parameter  int SEL_W = DEF_SEL_W,
    parameter  int DWELL = DEF_DWELL,
    localparam int N_CH  = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cont_mode,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel_out,
    output logic             busy,
    output logic [N_CH-1:0]  word_out,
    output logic             word_valid
);

    localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(N_CH - 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = dwell_load(DWELL);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [SEL_W-1:0]   next_sel;
    logic [N_CH-1:0]    shadow;
    logic [N_CH-1:0]    merged_word;
    logic               sample_en;
    logic               timer_load;
    logic               timer_dec;
    logic [DWELL_W-1:0] timer_value;
    logic               timer_zero;

    dwell_timer u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .dec        (timer_dec),
        .load_value (DWELL_LOAD),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        next_state = state;
        next_sel   = sel_out;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        sample_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    next_state = SETTLE;
                    next_sel   = '0;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    next_state = IDLE;
                    next_sel   = '0;
                end else if (timer_zero) begin
                    next_state = SAMPLE;
                end else begin
                    timer_dec = (timer_value != '0);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    next_state = IDLE;
                    next_sel   = '0;
                end else begin
                    sample_en = 1'b1;
                    if (sel_out == LAST_SEL) begin
                        next_state = DONE;
                    end else begin
                        next_state = SETTLE;
                        next_sel   = sel_out + SEL_W'(1);
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                next_sel = '0;
                if (!abort && cont_mode) begin
                    next_state = SETTLE;
                    timer_load = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_sel   = '0;
            end
        endcase
    end

    // The final channel's sample lands in word_out on the same edge it is taken.
    always_comb begin
        merged_word          = shadow;
        merged_word[sel_out] = y_in;
    end

    // word_valid is a pure strobe with no back-pressure: it is high for exactly
    // the one cycle in which word_out takes a new value, and consumers must
    // capture word_out in that cycle or read it later while it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_out    <= '0;
            busy       <= 1'b0;
            shadow     <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            state      <= next_state;
            sel_out    <= next_sel;
            busy       <= (next_state != IDLE);
            word_valid <= sample_en && (sel_out == LAST_SEL);
            if (sample_en) begin
                shadow[sel_out] <= y_in;
                if (sel_out == LAST_SEL) begin
                    word_out <= merged_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_select_scanner.sv
// Bench for mux_select_scanner: two instances (DWELL=1 and DWELL=3) driven by a
// shared 4-bit bank through a 4x1 mux model, checked against a timeline model.
module tb_mux_select_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cont_mode = 1'b0;
    logic [3:0] bank = 4'b0000;

    logic [1:0] sel_d1, sel_d3;
    logic       busy_d1, busy_d3;
    logic       valid_d1, valid_d3;
    logic [3:0] word_d1, word_d3;
    logic       y_d1, y_d3;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // 4x1 mux: each scanner's select picks one bit of the bank.
    assign y_d1 = bank[sel_d1];
    assign y_d3 = bank[sel_d3];

    always #5 clk = ~clk;

    mux_select_scanner #(.SEL_W(2), .DWELL(1)) u_d1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cont_mode  (cont_mode),
        .y_in       (y_d1),
        .sel_out    (sel_d1),
        .busy       (busy_d1),
        .word_out   (word_d1),
        .word_valid (valid_d1)
    );

    mux_select_scanner #(.SEL_W(2), .DWELL(3)) u_d3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cont_mode  (cont_mode),
        .y_in       (y_d3),
        .sel_out    (sel_d3),
        .busy       (busy_d3),
        .word_out   (word_d3),
        .word_valid (valid_d3)
    );

    // Timeline model: a scan is a numbered sequence of cycles t=1..P with
    // P = 4*(D+1); channel c owns cycles c*(D+1)+1 .. (c+1)*(D+1), the last of
    // which samples y. Cycle P+1 presents the word.
    int         dw[2] = '{1, 3};
    bit         m_act[2];
    int         m_t[2];
    logic [3:0] m_word[2];
    logic [3:0] m_samp[2];

    function automatic int m_sel(input int n);
        int p;
        p = 4 * (dw[n] + 1);
        if (!m_act[n]) return 0;
        if (m_t[n] <= p) return (m_t[n] - 1) / (dw[n] + 1);
        return 3;
    endfunction

    function automatic bit m_valid(input int n);
        return m_act[n] && (m_t[n] == 4 * (dw[n] + 1) + 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                m_act[n]  = 1'b0;
                m_t[n]    = 0;
                m_word[n] = 4'b0000;
                m_samp[n] = 4'b0000;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                int p;
                int s;
                p = 4 * (dw[n] + 1);
                s = m_sel(n);
                if (!m_act[n]) begin
                    if (start && !abort) begin
                        m_act[n] = 1'b1;
                        m_t[n]   = 1;
                    end
                end else if (abort) begin
                    m_act[n] = 1'b0;
                    m_t[n]   = 0;
                end else if (m_t[n] == p + 1) begin
                    if (cont_mode) begin
                        m_t[n] = 1;
                    end else begin
                        m_act[n] = 1'b0;
                        m_t[n]   = 0;
                    end
                end else begin
                    if (m_t[n] % (dw[n] + 1) == 0) m_samp[n][s] = bank[s];
                    if (m_t[n] == p) m_word[n] = m_samp[n];
                    m_t[n] = m_t[n] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_busy_d1", busy_d1, m_act[0]);
            chk("cmp_sel_d1", sel_d1, m_sel(0));
            chk("cmp_valid_d1", valid_d1, m_valid(0));
            chk("cmp_word_d1", word_d1, m_word[0]);
            chk("cmp_busy_d3", busy_d3, m_act[1]);
            chk("cmp_sel_d3", sel_d3, m_sel(1));
            chk("cmp_valid_d3", valid_d3, m_valid(1));
            chk("cmp_word_d3", word_d3, m_word[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Start is high across exactly one edge (edge k); returns in cycle k+1.
    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy_d1 || busy_d3) && i < 200) begin
            step();
            i++;
        end
        chk("idle_timeout", {busy_d1, busy_d3}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy_d1"}, busy_d1, 0);
        chk({tag, "_sel_d1"}, sel_d1, 0);
        chk({tag, "_valid_d1"}, valid_d1, 0);
        chk({tag, "_word_d1"}, word_d1, 0);
        chk({tag, "_busy_d3"}, busy_d3, 0);
        chk({tag, "_sel_d3"}, sel_d3, 0);
        chk({tag, "_valid_d3"}, valid_d3, 0);
        chk({tag, "_word_d3"}, word_d3, 0);
    endtask

    initial begin
        #250000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_sel[8];
        int cnt;
        exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

        // Reset values
        #1 rst = 1'b1;
        #1 chk_all_zero("reset");
        #20 rst = 1'b0;
        cmp_en = 1'b1;

        // Single scan, defaults, bank 1011
        bank = 4'b1011;
        pulse_start();
        for (int j = 1; j <= 8; j++) begin
            chk($sformatf("t1_sel_c%0d", j), sel_d1, exp_sel[j-1]);
            chk($sformatf("t1_novalid_c%0d", j), valid_d1, 0);
            step();
        end
        chk("t1_valid", valid_d1, 1);
        chk("t1_word", word_d1, 4'b1011);
        step();
        chk("t1_busy_low", busy_d1, 0);
        chk("t1_valid_low", valid_d1, 0);

        // Abort while sel_out = 2
        wait_idle();
        pulse_start();
        for (int j = 1; j < 5; j++) step();
        chk("ab_sel2", sel_d1, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", busy_d1, 0);
        chk("ab_sel", sel_d1, 0);
        chk("ab_valid", valid_d1, 0);
        chk("ab_word_kept", word_d1, 4'b1011);
        cnt = 0;
        for (int j = 0; j < 12; j++) begin
            if (valid_d1) cnt++;
            step();
        end
        chk("ab_no_valid", cnt, 0);

        // DWELL=3 instance, bank 0110
        bank = 4'b0110;
        wait_idle();
        pulse_start();
        for (int j = 1; j <= 16; j++) begin
            chk($sformatf("d3_sel_c%0d", j), sel_d3, (j - 1) / 4);
            chk($sformatf("d3_novalid_c%0d", j), valid_d3, 0);
            if (j == 9) begin
                chk("d1_valid_k9", valid_d1, 1);
                chk("d1_word_k9", word_d1, 4'b0110);
            end
            step();
        end
        chk("d3_valid_k17", valid_d3, 1);
        chk("d3_word_k17", word_d3, 4'b0110);

        // Start re-pulsed while busy is ignored
        bank = 4'b1101;
        wait_idle();
        pulse_start();
        cnt = 0;
        for (int j = 1; j <= 12; j++) begin
            if (valid_d1) cnt++;
            if (j == 3) chk("rs_sel1", sel_d1, 1);
            if (j == 9) begin
                chk("rs_valid_k9", valid_d1, 1);
                chk("rs_word_k9", word_d1, 4'b1101);
            end
            if (j == 3) start = 1'b1;
            if (j == 4) start = 1'b0;
            step();
        end
        chk("rs_one_valid", cnt, 1);

        // Continuous mode, bank changed during second scan's channel-0 settle
        wait_idle();
        bank = 4'b0001;
        cont_mode = 1'b1;
        pulse_start();
        cnt = 0;
        for (int j = 1; j <= 18; j++) begin
            if (valid_d1) cnt++;
            if (j == 9) begin
                chk("ct_valid1", valid_d1, 1);
                chk("ct_word1", word_d1, 4'b0001);
            end
            if (j == 10) begin
                chk("ct_no_idle", busy_d1, 1);
                chk("ct_sel_restart", sel_d1, 0);
                bank = 4'b1000;
            end
            if (j == 18) begin
                chk("ct_valid2", valid_d1, 1);
                chk("ct_word2", word_d1, 4'b1000);
                cont_mode = 1'b0;
            end
            step();
        end
        chk("ct_two_valids", cnt, 2);

        // Asynchronous reset mid-SETTLE, then a normal scan
        wait_idle();
        bank = 4'b0101;
        pulse_start();
        step();
        step();
        chk("rr_settle_sel1", sel_d1, 1);
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        pulse_start();
        for (int j = 1; j < 9; j++) step();
        chk("rr_valid", valid_d1, 1);
        chk("rr_word", word_d1, 4'b0101);

        // Randomised traffic against the model
        wait_idle();
        for (int j = 0; j < 500; j++) begin
            if (j % 60 == 0) cont_mode = ($urandom_range(0, 2) == 0);
            bank  = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 39) == 0);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        cont_mode = 1'b0;
        wait_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
